// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encodings and sampling constants.
// Also holds the 2-of-3 majority helper used for bit decisions.
package uart_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd3,
        S_BREAK = 3'd4
    } uart_state_e;

    localparam logic [3:0] SAMPLE_LO   = 4'd7;
    localparam logic [3:0] SAMPLE_MID  = 4'd8;
    localparam logic [3:0] SAMPLE_HI   = 4'd9;
    localparam logic [3:0] LAST_SAMPLE = 4'd15;
    localparam int         DATA_BITS   = 8;

    function automatic logic maj3(
        input logic a,
        input logic b,
        input logic c
    );
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_os_tick_gen.sv
// Oversample tick generator: one-cycle tick every DIV clocks.
// clear restarts the count so sampling can be phase-aligned to an edge.
module uart_os_tick_gen #(
    parameter int DIV = 325
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick
);

    localparam int              CW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0]   LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (clear || (cnt_q == LAST)) begin
            cnt_d = '0;
        end
    end

    assign tick = (cnt_q == LAST) && !clear;

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_rx_os16.sv
// 16x-oversampled 8N1 UART receiver with majority voting,
// false-start rejection, framing/overrun pulses and valid/ready output.
module uart_rx_os16
    import uart_pkg::*;
#(
    parameter int CLOCK_FREQ = 50000000,
    parameter int BAUD_RATE  = 9600,
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    input  logic       rx_ready,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       frame_err,
    output logic       overrun_err,
    output logic       rx_busy
);

    localparam int DIV = CLOCK_FREQ / (BAUD_RATE * OVERSAMPLE);

    uart_state_e state_q;
    logic        rx_meta_q;
    logic        rx_s_q;
    logic [3:0]  s_q;
    logic [2:0]  idx_q;
    logic [7:0]  shift_q;
    logic        smp_lo_q;
    logic        smp_mid_q;
    logic [7:0]  data_q;
    logic        valid_q;
    logic        ferr_q;
    logic        oerr_q;
    logic        busy_q;

    logic tick;
    logic start_det;
    logic maj;
    logic at_hi;
    logic at_last;

    assign start_det = (state_q == S_IDLE) && !rx_s_q;
    assign maj       = maj3(smp_lo_q, smp_mid_q, rx_s_q);
    assign at_hi     = tick && (s_q == SAMPLE_HI);
    assign at_last   = tick && (s_q == LAST_SAMPLE);

    uart_os_tick_gen #(
        .DIV (DIV)
    ) u_tick (
        .clk   (clk),
        .rst   (rst),
        .clear (start_det),
        .tick  (tick)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            s_q       <= '0;
            idx_q     <= '0;
            shift_q   <= '0;
            smp_lo_q  <= 1'b0;
            smp_mid_q <= 1'b0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
            oerr_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
            ferr_q    <= 1'b0;
            oerr_q    <= 1'b0;

            if (valid_q && rx_ready) begin
                valid_q <= 1'b0;
            end

            if (tick) begin
                s_q <= s_q + 4'd1;
                if (s_q == SAMPLE_LO) begin
                    smp_lo_q <= rx_s_q;
                end
                if (s_q == SAMPLE_MID) begin
                    smp_mid_q <= rx_s_q;
                end
            end

            unique case (state_q)
                S_IDLE: begin
                    if (!rx_s_q) begin
                        state_q <= S_START;
                        s_q     <= '0;
                        idx_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                S_START: begin
                    if (at_hi && maj) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end else if (at_last) begin
                        state_q <= S_DATA;
                        idx_q   <= '0;
                    end
                end
                S_DATA: begin
                    if (at_hi) begin
                        shift_q <= {maj, shift_q[7:1]};
                    end
                    if (at_last) begin
                        idx_q <= idx_q + 3'd1;
                        if (idx_q == 3'(DATA_BITS - 1)) begin
                            state_q <= S_STOP;
                        end
                    end
                end
                S_STOP: begin
                    // Leave half a bit early so the next start edge is not missed
                    if (at_hi) begin
                        if (maj) begin
                            state_q <= S_IDLE;
                            busy_q  <= 1'b0;
                            if (!valid_q || rx_ready) begin
                                data_q  <= shift_q;
                                valid_q <= 1'b1;
                            end else begin
                                oerr_q <= 1'b1;
                            end
                        end else begin
                            state_q <= S_BREAK;
                            ferr_q  <= 1'b1;
                        end
                    end
                end
                S_BREAK: begin
                    if (rx_s_q) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign rx_data     = data_q;
    assign rx_valid    = valid_q;
    assign frame_err   = ferr_q;
    assign overrun_err = oerr_q;
    assign rx_busy     = busy_q;

endmodule

// File: tb/tb_uart_rx_os16.sv
// Directed bench for uart_rx_os16 at DIV=2 (32 clocks per bit).
// Event counters are kept by a negedge monitor; tests compare deltas.
module tb_uart_rx_os16;

    localparam int BIT_CLKS = 32;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       rx = 1'b1;
    logic       rx_ready = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       overrun_err;
    logic       rx_busy;

    int checks = 0;
    int errors = 0;

    int vcyc_cnt = 0;
    int vrise_cnt = 0;
    int ferr_cnt = 0;
    int oerr_cnt = 0;
    logic prev_valid = 1'b0;

    always #5 clk = ~clk;

    uart_rx_os16 #(
        .CLOCK_FREQ (3200000),
        .BAUD_RATE  (100000),
        .OVERSAMPLE (16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rx          (rx),
        .rx_ready    (rx_ready),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .frame_err   (frame_err),
        .overrun_err (overrun_err),
        .rx_busy     (rx_busy)
    );

    always @(negedge clk) begin
        if (rx_valid) vcyc_cnt++;
        if (rx_valid && !prev_valid) vrise_cnt++;
        if (frame_err) ferr_cnt++;
        if (overrun_err) oerr_cnt++;
        prev_valid = rx_valid;
    end

    typedef struct {
        logic [7:0] data;
        logic       stop;
        logic       glitch;
        logic [7:0] exp_data;
        int         exp_vcyc;
        int         exp_ferr;
    } vec_t;

    vec_t vecs[6];

    int b_vcyc, b_vrise, b_ferr, b_oerr;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)",
                     name, act, act, exp, exp);
        end
    endtask

    task automatic snap();
        @(negedge clk);
        b_vcyc  = vcyc_cnt;
        b_vrise = vrise_cnt;
        b_ferr  = ferr_cnt;
        b_oerr  = oerr_cnt;
        @(posedge clk);
        #1;
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive_bit(input logic b, input logic glitch);
        for (int i = 0; i < BIT_CLKS; i++) begin
            rx = (glitch && i == 18) ? ~b : b;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop,
                              input logic glitch);
        drive_bit(1'b0, 1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i], glitch);
        drive_bit(stop, 1'b0);
        rx = 1'b1;
    endtask

    task automatic chk_outputs_zero(input string tag);
        @(negedge clk);
        chk({tag, "_data"}, int'(rx_data), 0);
        chk({tag, "_valid"}, int'(rx_valid), 0);
        chk({tag, "_ferr"}, int'(frame_err), 0);
        chk({tag, "_oerr"}, int'(overrun_err), 0);
        chk({tag, "_busy"}, int'(rx_busy), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        vecs[0] = '{8'hA5, 1'b1, 1'b0, 8'hA5, 1, 0};
        vecs[1] = '{8'h3C, 1'b0, 1'b0, 8'hA5, 0, 1};
        vecs[2] = '{8'h55, 1'b1, 1'b0, 8'h55, 1, 0};
        vecs[3] = '{8'hF0, 1'b1, 1'b1, 8'hF0, 1, 0};
        vecs[4] = '{8'h00, 1'b1, 1'b0, 8'h00, 1, 0};
        vecs[5] = '{8'hFF, 1'b1, 1'b1, 8'hFF, 1, 0};

        rst = 1'b0;
        cycles(4);
        chk_outputs_zero("reset");
        rst = 1'b1;
        cycles(8);

        foreach (vecs[k]) begin
            snap();
            send_frame(vecs[k].data, vecs[k].stop, vecs[k].glitch);
            cycles(40);
            @(negedge clk);
            chk($sformatf("v%0d_data", k), int'(rx_data), int'(vecs[k].exp_data));
            chk($sformatf("v%0d_vcyc", k), vcyc_cnt - b_vcyc, vecs[k].exp_vcyc);
            chk($sformatf("v%0d_ferr", k), ferr_cnt - b_ferr, vecs[k].exp_ferr);
            chk($sformatf("v%0d_oerr", k), oerr_cnt - b_oerr, 0);
            chk($sformatf("v%0d_busy", k), int'(rx_busy), 0);
            @(posedge clk);
            #1;
        end

        // False start: a quarter-bit low pulse
        snap();
        begin
            int seen_busy = 0;
            int waited = 0;
            rx = 1'b0;
            for (int i = 0; i < 8; i++) begin
                @(posedge clk);
                #1;
                if (rx_busy) seen_busy = 1;
            end
            rx = 1'b1;
            while (rx_busy && waited < 20) begin
                @(posedge clk);
                #1;
                waited++;
            end
            chk("fs_busy_seen", seen_busy, 1);
            chk("fs_busy_drop", int'(rx_busy), 0);
        end
        cycles(40);
        chk("fs_vcyc", vcyc_cnt - b_vcyc, 0);
        chk("fs_ferr", ferr_cnt - b_ferr, 0);
        chk("fs_oerr", oerr_cnt - b_oerr, 0);

        // Overrun with consumer stalled
        rx_ready = 1'b0;
        snap();
        send_frame(8'h11, 1'b1, 1'b0);
        cycles(40);
        send_frame(8'h22, 1'b1, 1'b0);
        cycles(40);
        @(negedge clk);
        chk("ov_data", int'(rx_data), 8'h11);
        chk("ov_valid", int'(rx_valid), 1);
        chk("ov_rise", vrise_cnt - b_vrise, 1);
        chk("ov_oerr", oerr_cnt - b_oerr, 1);
        chk("ov_ferr", ferr_cnt - b_ferr, 0);
        @(posedge clk);
        #1;
        rx_ready = 1'b1;
        @(negedge clk);
        chk("ov_valid_pre", int'(rx_valid), 1);
        @(negedge clk);
        chk("ov_valid_drop", int'(rx_valid), 0);
        @(posedge clk);
        #1;
        cycles(8);

        // Reset in the middle of DATA
        snap();
        drive_bit(1'b0, 1'b0);
        drive_bit(1'b1, 1'b0);
        drive_bit(1'b0, 1'b0);
        rx = 1'b0;
        cycles(10);
        rst = 1'b0;
        cycles(3);
        chk_outputs_zero("mid_rst");
        rx = 1'b1;
        cycles(2);
        rst = 1'b1;
        cycles(8);
        send_frame(8'h81, 1'b1, 1'b0);
        cycles(40);
        @(negedge clk);
        chk("rst_data", int'(rx_data), 8'h81);
        chk("rst_vcyc", vcyc_cnt - b_vcyc, 1);
        chk("rst_ferr", ferr_cnt - b_ferr, 0);
        chk("rst_oerr", oerr_cnt - b_oerr, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
